capture_buffer_ctrl: RTL

CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

---
 rtl/capture_buffer_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/capture_buffer_ctrl.sv
// Capture buffer controller: streams BUFFER_LENGTH I/Q samples into a buffer
// through a write channel, then replays them from the buffer to the output.
module capture_buffer_ctrl #(
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12,
    parameter int BUFFER_LENGTH = 64,
    parameter int INDEX_BITS    = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [I_BITS-1:0]     in_i,
    input  logic signed [Q_BITS-1:0]     in_q,
    output logic [INDEX_BITS-1:0]        m_axi_waddr,
    output logic [I_BITS+Q_BITS-1:0]     m_axi_wdata,
    output logic                         m_axi_wvalid,
    input  logic                         s_axi_wready,
    input  logic                         s_axi_bvalid,
    input  logic                         s_axi_bresp,
    output logic                         m_axi_bready,
    output logic [INDEX_BITS-1:0]        m_axi_raddr,
    output logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic                         s_axi_rvalid,
    input  logic signed [I_BITS-1:0]     buf_i,
    input  logic signed [Q_BITS-1:0]     buf_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [I_BITS-1:0]     out_i,
    output logic signed [Q_BITS-1:0]     out_q,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int CW = INDEX_BITS + 1;
    localparam logic [CW-1:0] LEN = CW'(BUFFER_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q;
    logic [CW-1:0]               wr_cnt_q;
    logic [CW-1:0]               rsp_cnt_q;
    logic [CW-1:0]               rd_cnt_q;
    logic                        wvalid_q;
    logic [INDEX_BITS-1:0]       waddr_q;
    logic [I_BITS+Q_BITS-1:0]    wdata_q;
    logic                        out_valid_q;
    logic signed [I_BITS-1:0]    out_i_q;
    logic signed [Q_BITS-1:0]    out_q_q;
    logic                        error_q;

    logic          in_fill;
    logic          in_drain;
    logic [CW-1:0] issue_cnt;
    logic          in_fire;
    logic          w_fire;
    logic          b_fire;
    logic          r_fire;
    logic          o_fire;

    assign in_fill  = (state_q == S_FILL);
    assign in_drain = (state_q == S_DRAIN);

    // Address of the next sample: a beat retiring this cycle frees its slot.
    assign issue_cnt = wr_cnt_q + CW'(wvalid_q);

    assign in_ready     = in_fill && (issue_cnt < LEN) && (!wvalid_q || s_axi_wready);
    assign in_fire      = in_valid && in_ready;
    assign w_fire       = wvalid_q && s_axi_wready;
    assign m_axi_bready = in_fill;
    assign b_fire       = s_axi_bvalid && m_axi_bready && (rsp_cnt_q < LEN);

    assign m_axi_rvalid = in_drain && (rd_cnt_q < LEN);
    assign m_axi_raddr  = rd_cnt_q[INDEX_BITS-1:0];
    assign m_axi_rready = in_drain && (!out_valid_q || out_ready);
    assign r_fire       = s_axi_rvalid && m_axi_rready && m_axi_rvalid;
    assign o_fire       = out_valid_q && out_ready;

    assign m_axi_waddr  = waddr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wvalid = wvalid_q;
    assign out_valid    = out_valid_q;
    assign out_i        = out_i_q;
    assign out_q        = out_q_q;
    assign error        = error_q;
    assign busy         = in_fill || in_drain;
    assign done         = (state_q == S_DONE);

    // NOTE: all state lives in this one block and uses non-blocking assignments,
    // so every read inside it sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rsp_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            wvalid_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            error_q     <= 1'b0;
        end else if (abort) begin
            // NOTE: counters and error are left alone here; FILL entry re-arms them.
            state_q     <= S_IDLE;
            wvalid_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_FILL;
                        wr_cnt_q    <= '0;
                        rsp_cnt_q   <= '0;
                        rd_cnt_q    <= '0;
                        error_q     <= 1'b0;
                        wvalid_q    <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end

                S_FILL: begin
                    if (in_fire) begin
                        wdata_q  <= {in_i, in_q};
                        waddr_q  <= issue_cnt[INDEX_BITS-1:0];
                        wvalid_q <= 1'b1;
                    end else if (w_fire) begin
                        wvalid_q <= 1'b0;
                    end

                    if (w_fire) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                    end

                    if (b_fire) begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        if (s_axi_bresp) begin
                            error_q <= 1'b1;
                        end
                    end

                    if ((wr_cnt_q == LEN) && (rsp_cnt_q == LEN)) begin
                        state_q <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (r_fire) begin
                        out_i_q     <= buf_i;
                        out_q_q     <= buf_q;
                        out_valid_q <= 1'b1;
                        rd_cnt_q    <= rd_cnt_q + 1'b1;
                    end else if (o_fire) begin
                        out_valid_q <= 1'b0;
                    end

                    if ((rd_cnt_q == LEN) && !out_valid_q) begin
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
